// File: rtl/ocp_block_copy.sv
// ---------------------------------------------------------------------------
// ocp_block_copy
//
// OCP initiator that copies a block of 32-bit words from a source address
// range to a destination address range. Each word is moved with one READ
// followed by one WRITE, so at most one transaction is outstanding at a time.
//
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   i_start          start request, sampled only while idle
//   i_src, i_dst     byte addresses (bits [1:0] treated as zero)
//   i_count          number of words to copy (0 = done pulse, no bus traffic)
//   o_busy           high while a copy is in progress
//   o_done           one-cycle pulse on completion or abort
//   o_err            sticky error flag, cleared by the next accepted start
//   o_MAddr, o_MCmd, o_MData, o_MByteEn   OCP master request fields
//   i_SCmdAccept, i_SData, i_SResp        OCP slave accept/response
// ---------------------------------------------------------------------------
module ocp_block_copy #(
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  input  logic [CNT_WIDTH-1:0]  i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [DATA_WIDTH-1:0] o_MData,
  output logic [BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
);

  // OCP command and response encodings
  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_FAIL = 2'b10;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  // FSM states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_CMD  = 3'd1;
  localparam logic [2:0] S_RD_RESP = 3'd2;
  localparam logic [2:0] S_WR_CMD  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  localparam logic [BEN_WIDTH-1:0]  BEN_ALL   = {BEN_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            mcmd_q, mcmd_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [BEN_WIDTH-1:0]  mben_q, mben_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Word-aligned views of the start addresses; the low two bits are dropped.
  logic [ADDR_WIDTH-1:0] src_aligned;
  logic [ADDR_WIDTH-1:0] dst_aligned;
  logic [ADDR_WIDTH-1:0] src_next;
  logic [ADDR_WIDTH-1:0] dst_next;
  logic                  unused_addr_lsbs;

  assign src_aligned      = {i_src[ADDR_WIDTH-1:2], 2'b00};
  assign dst_aligned      = {i_dst[ADDR_WIDTH-1:2], 2'b00};
  assign src_next         = src_q + WORD_STEP;   // wraps modulo 2^ADDR_WIDTH
  assign dst_next         = dst_q + WORD_STEP;
  assign unused_addr_lsbs = ^{i_src[1:0], i_dst[1:0]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mcmd_d  = mcmd_q;
    maddr_d = maddr_q;
    mben_d  = mben_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          src_d = src_aligned;
          dst_d = dst_aligned;
          cnt_d = i_count;
          err_d = 1'b0;
          if (i_count == '0) begin
            // Empty copy: just acknowledge, never touch the bus.
            done_d = 1'b1;
          end else begin
            state_d = S_RD_CMD;
            busy_d  = 1'b1;
            mcmd_d  = OCP_CMD_READ;
            maddr_d = src_aligned;
            mben_d  = BEN_ALL;
          end
        end
      end

      S_RD_CMD: begin
        if (i_SCmdAccept) begin
          mcmd_d  = OCP_CMD_IDLE;
          state_d = S_RD_RESP;
        end
      end

      S_RD_RESP: begin
        case (i_SResp)
          OCP_RESP_DVA: begin
            data_d  = i_SData;
            state_d = S_WR_CMD;
            mcmd_d  = OCP_CMD_WRITE;
            maddr_d = dst_q;
            mben_d  = BEN_ALL;
          end
          OCP_RESP_FAIL, OCP_RESP_ERR: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            mcmd_d  = OCP_CMD_IDLE;
          end
          default: ;  // NULL: keep waiting
        endcase
      end

      S_WR_CMD: begin
        if (i_SCmdAccept) begin
          mcmd_d  = OCP_CMD_IDLE;
          state_d = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        case (i_SResp)
          OCP_RESP_DVA: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              mcmd_d  = OCP_CMD_IDLE;
            end else begin
              src_d   = src_next;
              dst_d   = dst_next;
              state_d = S_RD_CMD;
              mcmd_d  = OCP_CMD_READ;
              maddr_d = src_next;
              mben_d  = BEN_ALL;
            end
          end
          OCP_RESP_FAIL, OCP_RESP_ERR: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            mcmd_d  = OCP_CMD_IDLE;
          end
          default: ;  // NULL: keep waiting
        endcase
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        mcmd_d  = OCP_CMD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mcmd_q  <= OCP_CMD_IDLE;
      maddr_q <= '0;
      mben_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mcmd_q  <= mcmd_d;
      maddr_q <= maddr_d;
      mben_q  <= mben_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Write data comes straight from the captured read data register, which
  // only changes on a read DVA, so it is stable for the whole WRITE.
  assign o_MCmd    = mcmd_q;
  assign o_MAddr   = maddr_q;
  assign o_MData   = data_q;
  assign o_MByteEn = mben_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_ocp_block_copy.sv
module tb_ocp_block_copy;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [1:0] R_NULL   = 2'd0;
  localparam logic [1:0] R_DVA    = 2'd1;
  localparam logic [1:0] R_ERR    = 2'd3;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_src = '0;
  logic [31:0] i_dst = '0;
  logic [15:0] i_count = '0;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_MAddr, o_MData;
  logic [2:0]  o_MCmd;
  logic [3:0]  o_MByteEn;
  logic        i_SCmdAccept;
  logic [31:0] i_SData = '0;
  logic [1:0]  i_SResp = R_NULL;

  always #5 clk = ~clk;

  ocp_block_copy dut (
    .clk(clk), .nrst(nrst), .i_start(i_start), .i_src(i_src), .i_dst(i_dst),
    .i_count(i_count), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MData(o_MData), .o_MByteEn(o_MByteEn),
    .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp)
  );

  // ---------------- behavioural RAM slave ----------------
  logic [31:0] mem [0:255];
  int          stall_cfg = 0;
  int          err_read_idx = -1;
  int          wait_ctr = 0;
  int          rd_seen = 0;
  logic        clr = 1'b0;
  logic        pwe = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pdata = '0;

  assign i_SCmdAccept = (o_MCmd != CMD_IDLE) && (wait_ctr >= stall_cfg);

  always @(posedge clk) begin
    i_SResp <= R_NULL;
    if (pwe) mem[paddr] <= pdata;
    if (clr) begin
      wait_ctr <= 0;
      rd_seen  <= 0;
    end else if (o_MCmd != CMD_IDLE) begin
      if (i_SCmdAccept) begin
        wait_ctr <= 0;
        if (o_MCmd == CMD_RD) begin
          rd_seen <= rd_seen + 1;
          i_SData <= mem[o_MAddr[9:2]];
          i_SResp <= (rd_seen == err_read_idx) ? R_ERR : R_DVA;
        end else begin
          mem[o_MAddr[9:2]] <= o_MData;
          i_SResp <= R_DVA;
        end
      end else begin
        wait_ctr <= wait_ctr + 1;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int          cyc = 0;
  int          cyc0 = 0;
  int          log_n = 0, nonidle_cnt = 0, unstable = 0, done_cnt = 0;
  logic        busy_seen = 1'b0;
  logic [2:0]  log_cmd  [16];
  logic [31:0] log_addr [16];
  logic [31:0] log_data [16];
  int          log_cyc  [16];
  logic        prev_pending = 1'b0;
  logic [2:0]  prev_cmd = '0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic [3:0]  prev_ben = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr) begin
      log_n <= 0; nonidle_cnt <= 0; unstable <= 0; done_cnt <= 0;
      busy_seen <= 1'b0; prev_pending <= 1'b0;
    end else begin
      prev_pending <= (o_MCmd != CMD_IDLE) && !i_SCmdAccept;
      prev_cmd  <= o_MCmd;
      prev_addr <= o_MAddr;
      prev_data <= o_MData;
      prev_ben  <= o_MByteEn;
      if (prev_pending && (o_MCmd !== prev_cmd || o_MAddr !== prev_addr ||
                           o_MData !== prev_data || o_MByteEn !== prev_ben))
        unstable <= unstable + 1;
      if (o_MCmd != CMD_IDLE) nonidle_cnt <= nonidle_cnt + 1;
      if (o_busy) busy_seen <= 1'b1;
      if (o_done) done_cnt <= done_cnt + 1;
      if (o_MCmd != CMD_IDLE && i_SCmdAccept) begin
        if (log_n < 16) begin
          log_cmd[log_n]  <= o_MCmd;
          log_addr[log_n] <= o_MAddr;
          log_data[log_n] <= o_MData;
          log_cyc[log_n]  <= cyc;
        end
        log_n <= log_n + 1;
        $display("[cycle %0d] %s addr=%08h data=%08h ben=%h", cyc - cyc0 + 1,
                 (o_MCmd == CMD_RD) ? "READ " : "WRITE", o_MAddr, o_MData, o_MByteEn);
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pwe = 1'b1; paddr = idx; pdata = val;
    @(negedge clk);
    pwe = 1'b0;
  endtask

  task automatic clear_logs();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    i_src = s; i_dst = d; i_count = n; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    cyc0 = cyc;
  endtask

  // Returns the cycle (1 = first cycle after the start edge) in which o_done is seen.
  task automatic wait_done(input string tag, output int rel);
    rel = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_done) begin
        rel = cyc - cyc0 + 1;
        break;
      end
    end
    if (rel < 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int n_before;

    // ---- reset values ----
    #2 nrst = 1'b0;
    #1;
    chk("rst_mcmd", o_MCmd, CMD_IDLE);
    chk("rst_maddr", o_MAddr, 0);
    chk("rst_mdata", o_MData, 0);
    chk("rst_mben", o_MByteEn, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    poke(8'h00, 32'h11111111);
    poke(8'h01, 32'h22222222);
    poke(8'h02, 32'h33333333);
    poke(8'h10, 32'hA5A5A5A5);
    poke(8'h11, 32'h5A5A5A5A);
    for (int i = 0; i < 4; i++) poke(8'h20 + 8'(i), 32'hCAFE0000 + 32'(i));
    poke(8'hFF, 32'hDEADBEEF);

    // ---- basic 3-word copy, zero-wait slave ----
    clear_logs();
    start_copy(32'h000, 32'h100, 16'd3);
    wait_done("t1", rel);
    chk("t1_done_cycle", rel, 13);
    chk("t1_err", o_err, 0);
    chk("t1_busy_at_done", o_busy, 0);
    chk("t1_ntxn", log_n, 6);
    chk("t1_rd0_addr", log_addr[0], 32'h0);
    chk("t1_rd0_cycle", log_cyc[0] - cyc0 + 1, 1);
    chk("t1_wr0_cmd", log_cmd[1], CMD_WR);
    chk("t1_wr0_addr", log_addr[1], 32'h100);
    chk("t1_wr0_data", log_data[1], 32'h11111111);
    chk("t1_rd1_addr", log_addr[2], 32'h4);
    chk("t1_rd1_cycle", log_cyc[2] - cyc0 + 1, 5);
    chk("t1_busy_seen", busy_seen, 1);
    chk("t1_mem40", mem[8'h40], 32'h11111111);
    chk("t1_mem41", mem[8'h41], 32'h22222222);
    chk("t1_mem42", mem[8'h42], 32'h33333333);
    @(negedge clk);
    chk("t1_done_one_cycle", o_done, 0);

    // ---- count = 0 ----
    clear_logs();
    start_copy(32'h000, 32'h200, 16'd0);
    wait_done("t2", rel);
    chk("t2_done_cycle", rel, 1);
    repeat (3) @(negedge clk);
    chk("t2_no_bus", nonidle_cnt, 0);
    chk("t2_no_busy", busy_seen, 0);

    // ---- slave stalls 3 cycles on every command ----
    stall_cfg = 3;
    clear_logs();
    start_copy(32'h040, 32'h180, 16'd2);
    wait_done("t3", rel);
    chk("t3_unstable", unstable, 0);
    chk("t3_cmd_cycles", nonidle_cnt, 16);
    chk("t3_ntxn", log_n, 4);
    chk("t3_mem60", mem[8'h60], 32'hA5A5A5A5);
    chk("t3_mem61", mem[8'h61], 32'h5A5A5A5A);
    chk("t3_err", o_err, 0);
    stall_cfg = 0;

    // ---- error response on the second read ----
    err_read_idx = 1;
    clear_logs();
    start_copy(32'h080, 32'h1C0, 16'd4);
    wait_done("t4", rel);
    chk("t4_done_cycle", rel, 7);
    chk("t4_err", o_err, 1);
    chk("t4_busy", o_busy, 0);
    n_before = log_n;
    repeat (6) @(negedge clk);
    chk("t4_ntxn", log_n, 3);
    chk("t4_no_more_txn", log_n, n_before);
    chk("t4_wr_cmd", log_cmd[1], CMD_WR);
    chk("t4_wr_data", log_data[1], 32'hCAFE0000);
    chk("t4_mem70", mem[8'h70], 32'hCAFE0000);
    chk("t4_err_sticky", o_err, 1);
    err_read_idx = -1;
    clear_logs();
    start_copy(32'h088, 32'h1D0, 16'd1);
    chk("t4_err_cleared", o_err, 0);
    wait_done("t4b", rel);
    chk("t4b_done_cycle", rel, 5);
    chk("t4b_mem74", mem[8'h74], 32'hCAFE0002);

    // ---- address wrap and misaligned addresses ----
    clear_logs();
    start_copy(32'hFFFFFFFC, 32'h140, 16'd2);
    wait_done("t5", rel);
    chk("t5_rd0_addr", log_addr[0], 32'hFFFFFFFC);
    chk("t5_rd1_addr", log_addr[2], 32'h00000000);
    chk("t5_mem50", mem[8'h50], 32'hDEADBEEF);
    chk("t5_mem51", mem[8'h51], 32'h11111111);
    clear_logs();
    start_copy(32'h103, 32'h1E2, 16'd1);
    wait_done("t5b", rel);
    chk("t5b_rd_addr", log_addr[0], 32'h100);
    chk("t5b_wr_addr", log_addr[1], 32'h1E0);
    chk("t5b_mem78", mem[8'h78], 32'h11111111);

    // ---- reset during WR_CMD ----
    stall_cfg = 2;
    clear_logs();
    start_copy(32'h000, 32'h1F0, 16'd2);
    rel = -1;
    for (int i = 0; i < 40; i++) begin
      if (o_MCmd == CMD_WR) begin
        rel = i;
        break;
      end
      @(negedge clk);
    end
    chk("t6_reached_write", (rel >= 0), 1);
    #2 nrst = 1'b0;
    #1;
    chk("t6_mcmd", o_MCmd, CMD_IDLE);
    chk("t6_maddr", o_MAddr, 0);
    chk("t6_mdata", o_MData, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_done", o_done, 0);
    chk("t6_err", o_err, 0);
    stall_cfg = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done_pulse", done_cnt, 0);
    chk("t6_idle_after", o_MCmd, CMD_IDLE);
    clear_logs();
    start_copy(32'h000, 32'h1F0, 16'd3);
    wait_done("t6b", rel);
    chk("t6b_done_cycle", rel, 13);
    chk("t6b_mem7c", mem[8'h7C], 32'h11111111);
    chk("t6b_mem7d", mem[8'h7D], 32'h22222222);
    chk("t6b_mem7e", mem[8'h7E], 32'h33333333);
    chk("t6b_err", o_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
